// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline front end.
// Bit 0 is the MSB on every bus ([0:WORD_W-1] ordering).
package pipeline_pkg;

    localparam int WORD_W = 32;

    typedef logic [0:WORD_W-1] word_t;

    localparam word_t NOP_INSTR = 32'h0000_0000;
    localparam word_t PC_INCR   = 32'd4;

    // One fetch queue slot: address of the following instruction, then the instruction.
    typedef struct packed {
        word_t next_pc;
        word_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched instructions with a synchronous flush.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    output logic [CNT_W-1:0]   count,
    output fetch_entry_t       head
);

    fetch_entry_t       mem_q [DEPTH];
    fetch_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Next-state for pointers, occupancy and storage; flush beats push and pop.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count==0 already marks every slot dead.
        mem_q <= mem_d;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, IMEM request issue, epoch-tagged response
// capture and the fetch queue feeding IF/ID.
// Optional feature: define IF_FETCH_CNT_EN to add the fetch_count output.
module instruction_fetch
    import pipeline_pkg::*;
#(
    parameter word_t RESET_PC  = 32'h0000_0000,
    parameter int    BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        leap,
    input  logic [0:31] leap_addr,
    output logic        imem_req,
    output logic [0:31] imem_addr,
    input  logic [0:31] imem_data,
    output logic        if_valid,
    output logic [0:31] if_nextPC,
    output logic [0:31] if_instr
`ifdef IF_FETCH_CNT_EN
  , output logic [0:31] fetch_count
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    word_t            pc_q, pc_d;
    word_t            resp_next_pc_q, resp_next_pc_d;
    logic             inflight_q, inflight_d;
    logic             tag_q, tag_d;
    logic             epoch_q, epoch_d;
    logic             issue, pop, push;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W:0]   occupancy;
    fetch_entry_t     head;

    // Issue, pop and response-acceptance decisions for this cycle.
    always_comb begin
        if_valid  = (q_count != '0);
        pop       = if_valid & ~stall & ~leap;
        occupancy = {1'b0, q_count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
        // Gating with reset keeps the request low while reset is held.
        issue     = reset & ~leap & (occupancy < (CNT_W+1)'(BUF_DEPTH));
        // A response from an older epoch, or one arriving during a redirect, is dropped.
        push      = inflight_q & (tag_q == epoch_q) & ~leap;
    end

    // Next PC, in-flight bookkeeping and epoch; a redirect outranks issue.
    always_comb begin
        pc_d           = pc_q;
        resp_next_pc_d = resp_next_pc_q;
        tag_d          = tag_q;
        inflight_d     = issue;
        epoch_d        = epoch_q ^ leap;
        if (leap) begin
            pc_d = {leap_addr[0:29], 2'b00};
        end else if (issue) begin
            pc_d           = pc_q + PC_INCR;
            resp_next_pc_d = pc_q + PC_INCR;
            tag_d          = epoch_q;
        end
    end

    // Fetch state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q           <= RESET_PC;
            resp_next_pc_q <= '0;
            inflight_q     <= 1'b0;
            tag_q          <= 1'b0;
            epoch_q        <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            resp_next_pc_q <= resp_next_pc_d;
            inflight_q     <= inflight_d;
            tag_q          <= tag_d;
            epoch_q        <= epoch_d;
        end
    end

    fetch_queue #(
        .DEPTH (BUF_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (reset),
        .flush      (leap),
        .push       (push),
        .push_entry ({resp_next_pc_q, imem_data}),
        .pop        (pop),
        .count      (q_count),
        .head       (head)
    );

    // Outputs toward IMEM and IF/ID; a bubble presents zeros.
    always_comb begin
        imem_req  = issue;
        imem_addr = pc_q;
        if_instr  = if_valid ? head.instr   : NOP_INSTR;
        if_nextPC = if_valid ? head.next_pc : '0;
    end

`ifdef IF_FETCH_CNT_EN
    logic [0:31] fetch_count_q, fetch_count_d;

    // Delivered-instruction counter, wrapping modulo 2^32.
    always_comb begin
        fetch_count_d = fetch_count_q + 32'(pop);
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fetch_count_q <= '0;
        else        fetch_count_q <= fetch_count_d;
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, streaming, stall, redirect,
// redirect under stall with a full queue, PC wrap, and mid-stream reset.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset, stall, leap;
    logic [0:31] leap_addr;
    logic        imem_req;
    logic [0:31] imem_addr, imem_data;
    logic        if_valid;
    logic [0:31] if_nextPC, if_instr;
`ifdef IF_FETCH_CNT_EN
    logic [0:31] fetch_count;
`endif

    int checks = 0;
    int errors = 0;

    instruction_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .leap      (leap),
        .leap_addr (leap_addr),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .if_valid  (if_valid),
        .if_nextPC (if_nextPC),
        .if_instr  (if_instr)
`ifdef IF_FETCH_CNT_EN
      , .fetch_count (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    // IMEM image: address 0 holds 0x20010005, others a recognisable address tag.
    function automatic logic [0:31] mem_word(input logic [0:31] a);
        logic [0:15] lo;
        lo = a[16:31];
        return (a == 32'h0) ? 32'h2001_0005 : {16'hC0DE, lo};
    endfunction

    // One-cycle-latency memory; garbage when no request was made.
    always @(posedge clk) imem_data <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    // Advance to the next cycle, landing 2 time units after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Hold reset for one cycle, release it; returns inside cycle 0 (+3).
    task automatic apply_reset();
        @(posedge clk);
        #1 reset = 1'b0; stall = 1'b0; leap = 1'b0; leap_addr = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        #2;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1 reset = 1'b0; stall = 1'b0; leap = 1'b0; leap_addr = '0;
        #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", if_instr); end
        checks++; if (if_nextPC !== 32'h0) begin errors++; $display("FAIL rst_nextpc got %h exp 0", if_nextPC); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
`ifdef IF_FETCH_CNT_EN
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL rst_fcnt got %h exp 0", fetch_count); end
`endif
    endtask

    task automatic test_stream();
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL str_req c%0d got %b exp 1", k, imem_req); end
            checks++; if (imem_addr !== 32'(4*k)) begin errors++; $display("FAIL str_addr c%0d got %h exp %h", k, imem_addr, 32'(4*k)); end
            if (k < 2) begin
                checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL str_valid c%0d got %b exp 0", k, if_valid); end
                checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL str_bubble c%0d got %h exp 0", k, if_instr); end
            end else begin
                checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL str_valid c%0d got %b exp 1", k, if_valid); end
                checks++; if (if_nextPC !== 32'(4*(k-1))) begin errors++; $display("FAIL str_nextpc c%0d got %h exp %h", k, if_nextPC, 32'(4*(k-1))); end
                checks++; if (if_instr !== mem_word(32'(4*(k-2)))) begin errors++; $display("FAIL str_instr c%0d got %h exp %h", k, if_instr, mem_word(32'(4*(k-2)))); end
`ifdef IF_FETCH_CNT_EN
                checks++; if (fetch_count !== 32'(k-2)) begin errors++; $display("FAIL str_fcnt c%0d got %0d exp %0d", k, fetch_count, k-2); end
`endif
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        logic [0:31] exp_np;
        apply_reset();
        next_cycle(); next_cycle();               // now cycle 2
        for (int k = 3; k <= 7; k++) begin
            next_cycle(); stall = 1'b1; #1;
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stl_req c%0d got %b exp 0", k, imem_req); end
            checks++; if (if_nextPC !== 32'h8) begin errors++; $display("FAIL stl_hold c%0d got %h exp 8", k, if_nextPC); end
            checks++; if (if_instr !== mem_word(32'h4)) begin errors++; $display("FAIL stl_instr c%0d got %h exp %h", k, if_instr, mem_word(32'h4)); end
        end
        next_cycle(); stall = 1'b0; #1;          // cycle 8: output resumes
        checks++; if (imem_addr !== 32'hC || imem_req !== 1'b1) begin errors++; $display("FAIL stl_resume_req got %b/%h exp 1/c", imem_req, imem_addr); end
        for (int k = 8; k <= 11; k++) begin
            exp_np = 32'(4*(k-6));               // 8, C, 10, 14
            checks++; if (if_valid !== 1'b1 || if_nextPC !== exp_np) begin errors++; $display("FAIL stl_seq c%0d got %b/%h exp 1/%h", k, if_valid, if_nextPC, exp_np); end
            if (k < 11) next_cycle();
        end
    endtask

    task automatic test_leap();
        apply_reset();
        next_cycle(); next_cycle();               // cycle 2: read of 0x8 issued
        next_cycle(); leap = 1'b1; leap_addr = 32'h103; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL lp_req got %b exp 0", imem_req); end
        next_cycle(); leap = 1'b0; #1;            // cycle 4
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL lp_flush got %b exp 0", if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL lp_target got %b/%h exp 1/100", imem_req, imem_addr); end
        next_cycle();                             // cycle 5
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL lp_gap got %b exp 0", if_valid); end
        next_cycle();                             // cycle 6
        checks++; if (if_valid !== 1'b1 || if_nextPC !== 32'h104) begin errors++; $display("FAIL lp_first got %b/%h exp 1/104", if_valid, if_nextPC); end
        checks++; if (if_instr !== mem_word(32'h100)) begin errors++; $display("FAIL lp_instr got %h exp %h", if_instr, mem_word(32'h100)); end
        next_cycle();
        checks++; if (if_nextPC !== 32'h108) begin errors++; $display("FAIL lp_second got %h exp 108", if_nextPC); end
    endtask

    task automatic test_leap_stall_full();
        apply_reset();
        next_cycle(); next_cycle();
        next_cycle(); stall = 1'b1; #1;           // cycle 3
        next_cycle();                             // cycle 4: queue full
        checks++; if (if_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL lsf_full got %b/%b exp 1/0", if_valid, imem_req); end
        next_cycle(); leap = 1'b1; leap_addr = 32'h200; #1;   // cycle 5
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL lsf_req got %b exp 0", imem_req); end
        next_cycle(); leap = 1'b0; stall = 1'b0; #1;          // cycle 6
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL lsf_flush got %b exp 0", if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL lsf_target got %b/%h exp 1/200", imem_req, imem_addr); end
        next_cycle(); next_cycle();               // cycle 8
        checks++; if (if_valid !== 1'b1 || if_nextPC !== 32'h204) begin errors++; $display("FAIL lsf_first got %b/%h exp 1/204", if_valid, if_nextPC); end
    endtask

    task automatic test_pc_wrap();
        apply_reset();
        next_cycle(); next_cycle();
        next_cycle(); leap = 1'b1; leap_addr = 32'hFFFF_FFFF; #1;   // low bits cleared
        next_cycle(); leap = 1'b0; #1;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr); end
        next_cycle();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got %h exp 0", imem_addr); end
        next_cycle();
        checks++; if (if_valid !== 1'b1 || if_nextPC !== 32'h0) begin errors++; $display("FAIL wrap_nextpc got %b/%h exp 1/0", if_valid, if_nextPC); end
        checks++; if (if_instr !== 32'hC0DE_FFFC) begin errors++; $display("FAIL wrap_instr got %h exp c0defffc", if_instr); end
    endtask

    task automatic test_midstream_reset();
        apply_reset();
        for (int k = 0; k < 4; k++) next_cycle();   // cycle 4, queue live
        reset = 1'b0; #1;
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL mid_out got %b/%b exp 0/0", if_valid, imem_req); end
        checks++; if (imem_addr !== 32'h0 || if_instr !== 32'h0) begin errors++; $display("FAIL mid_addr got %h/%h exp 0/0", imem_addr, if_instr); end
`ifdef IF_FETCH_CNT_EN
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL mid_fcnt got %h exp 0", fetch_count); end
`endif
        @(posedge clk);
        #1 reset = 1'b1;
        #2;                                         // cycle 0 again
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_c0 got %b/%h exp 1/0", imem_req, imem_addr); end
        next_cycle();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL mid_c1 got %b exp 0", if_valid); end
        next_cycle();
        checks++; if (if_valid !== 1'b1 || if_instr !== 32'h2001_0005 || if_nextPC !== 32'h4) begin
            errors++; $display("FAIL mid_c2 got %b/%h/%h exp 1/20010005/4", if_valid, if_instr, if_nextPC);
        end
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; leap = 1'b0; leap_addr = '0;
        test_reset();
        test_stream();
        test_stall();
        test_leap();
        test_leap_stall_full();
        test_pc_wrap();
        test_midstream_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
